nonce_scheduler: RTL and testbench
==================================

NONCE_SCHEDULER -- requirements
Module: nonce_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_WORKERS, default 4, number of attached hash worker engines (2..8).
REQ-002 The block SHALL have parameter NONCE_W, default 6, width of the nonce count and nonce tags.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  begin a job; sampled only in IDLE.
REQ-006 The block SHALL have port nonce_count  input  NONCE_W  number of nonces to hash, latched on start.
REQ-007 The block SHALL have port output_addr  input  16  base word address for results, latched on start.
REQ-008 The block SHALL have port busy  output  1  high in every state other than IDLE.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse when the job completes.
REQ-010 The block SHALL have port wk_start  output  NUM_WORKERS  per-worker one-cycle launch pulse.
REQ-011 The block SHALL have port wk_nonce  output  32  shared nonce bus, zero-extended tag, valid while any wk_start bit is high.
REQ-012 The block SHALL have port wk_done  input  NUM_WORKERS  per-worker result-valid level, held until acknowledged.
REQ-013 The block SHALL have port wk_result  input  32*NUM_WORKERS  packed results, worker i at bits [32i+31:32i].
REQ-014 The block SHALL have port wk_ack  output  NUM_WORKERS  per-worker one-cycle acknowledge pulse.
REQ-015 The block SHALL have ports mem_we  output  1, mem_addr  output  16 and mem_write_data  output  32, which form the result write port.

Function
REQ-016 The block SHALL implement states IDLE, RUN and FIN; all outputs SHALL be registered.
REQ-017 In IDLE, start=1 SHALL latch nonce_count and output_addr, clear next_nonce, written and all worker-busy flags, and enter RUN; start=1 with nonce_count=0 SHALL enter FIN instead.
REQ-018 Start in RUN or FIN SHALL be ignored.
REQ-019 In RUN, dispatch conditions SHALL be next_nonce<count and at least one worker not busy; at most one dispatch per cycle.
REQ-020 Dispatch SHALL select the lowest-index idle worker i, pulse wk_start[i] with wk_nonce=next_nonce in the following cycle, record tag[i]=next_nonce, set busy[i] and increment next_nonce.
REQ-021 The first dispatch SHALL appear as wk_start[0] in the cycle immediately after start is accepted.
REQ-022 Collection candidates SHALL be workers with wk_done[i]=1 and busy[i]=1; wk_done from a non-busy worker SHALL be ignored and never acknowledged.
REQ-023 Collection SHALL grant one candidate per cycle, round-robin from pointer rr (reset 0), searching rr, rr+1, ... modulo NUM_WORKERS; after a grant to i, rr SHALL become (i+1) mod NUM_WORKERS.
REQ-024 A grant to worker i detected at edge m SHALL, in the cycle after m, set mem_we=1, mem_addr=(output_addr+tag[i]) mod 2^16, mem_write_data=result i and wk_ack[i]=1, each for exactly one cycle.
REQ-025 A granted worker SHALL be excluded from candidacy until its ack completes, then SHALL clear busy[i] and SHALL NOT be redispatched earlier than the cycle after its ack.
REQ-026 Dispatch and collection SHALL proceed in the same cycle when both are eligible.
REQ-027 Each write SHALL increment written; RUN SHALL enter FIN when written equals count after the final write.
REQ-028 FIN SHALL pulse done for one cycle and return to IDLE on the next edge, with mem_we low.
REQ-029 Each nonce 0..count-1 SHALL be dispatched exactly once and written exactly once.

Reset
REQ-030 On reset=1, the block SHALL immediately, without waiting for clk, force state IDLE, and force busy, done, wk_start, wk_ack, mem_we, mem_addr, mem_write_data, wk_nonce, rr, next_nonce, written and all busy flags to 0.
REQ-031 In-flight worker results SHALL be discarded on reset; the block SHALL accept a fresh start in the first cycle after reset deasserts.

Verification
REQ-032 Bench SHALL cover: nonce_count=0, start -> done pulse one cycle after FIN entry, with no wk_start and no mem_we ever.
REQ-033 Bench SHALL cover: count=1, output_addr=0x0100, worker0 raises wk_done with 0xDEADBEEF 10 cycles after wk_start -> a single write to 0x0100 of 0xDEADBEEF, wk_ack[0] in the same cycle, then done.
REQ-034 Bench SHALL cover: count=16, 4 workers, fixed latency 20 cycles -> nonces 0-3 to workers 0-3 on consecutive cycles, and 16 writes to output_addr+0..15, each exactly once.
REQ-035 Bench SHALL cover: all 4 wk_done raised together with rr=0 -> acks and writes in order 0,1,2,3 on consecutive cycles, then rr=0.
REQ-036 Bench SHALL cover: output_addr=0xFFFE, count=4 -> write addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-037 Bench SHALL cover: reset pulsed mid-RUN with 2 workers busy -> all outputs 0 asynchronously, no late ack or write, and a restart dispatches nonce 0 to worker 0.

Source files
------------

// File: rtl/nonce_scheduler.sv
// Nonce scheduler: hands out nonces 0..count-1 to a pool of hash workers,
// collects their results round-robin and writes each result to
// output_addr + nonce. All outputs are registered.
module nonce_scheduler #(
  parameter int NUM_WORKERS = 4,
  parameter int NONCE_W     = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [NONCE_W-1:0]        nonce_count,
  input  logic [15:0]               output_addr,
  output logic                      busy,
  output logic                      done,
  output logic [NUM_WORKERS-1:0]    wk_start,
  output logic [31:0]               wk_nonce,
  input  logic [NUM_WORKERS-1:0]    wk_done,
  input  logic [32*NUM_WORKERS-1:0] wk_result,
  output logic [NUM_WORKERS-1:0]    wk_ack,
  output logic                      mem_we,
  output logic [15:0]               mem_addr,
  output logic [31:0]               mem_write_data
);

  localparam int          IW = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;
  localparam int unsigned NW = NUM_WORKERS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  // Control state
  logic [1:0]             r_state;
  logic [NONCE_W-1:0]     r_count;
  logic [15:0]            r_base;
  logic [NONCE_W-1:0]     r_next;
  logic [NONCE_W-1:0]     r_written;
  logic [NUM_WORKERS-1:0] r_busyf;
  logic [IW-1:0]          r_rr;
  logic [NONCE_W-1:0]     r_tag [NUM_WORKERS];

  // Registered outputs
  logic                   r_busy;
  logic                   r_done;
  logic [NUM_WORKERS-1:0] r_wk_start;
  logic [31:0]            r_wk_nonce;
  logic [NUM_WORKERS-1:0] r_wk_ack;
  logic                   r_mem_we;
  logic [15:0]            r_mem_addr;
  logic [31:0]            r_mem_wdata;

  // Combinational decisions
  logic [31:0]            w_res [NUM_WORKERS];
  logic [NUM_WORKERS-1:0] w_cand;
  logic                   w_hi_found;
  logic [IW-1:0]          w_hi_idx;
  logic                   w_lo_found;
  logic [IW-1:0]          w_lo_idx;
  logic                   w_gnt_valid;
  logic [IW-1:0]          w_gnt_idx;
  logic [IW-1:0]          w_rr_nxt;
  logic                   w_free_found;
  logic [IW-1:0]          w_d_idx;
  logic                   w_disp;
  logic [NUM_WORKERS-1:0] w_busy_nxt;

  assign busy           = r_busy;
  assign done           = r_done;
  assign wk_start       = r_wk_start;
  assign wk_nonce       = r_wk_nonce;
  assign wk_ack         = r_wk_ack;
  assign mem_we         = r_mem_we;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_wdata;

  for (genvar g = 0; g < NUM_WORKERS; g++) begin : g_res
    assign w_res[g] = wk_result[32*g +: 32];
  end

  // Round-robin grant: a worker currently being acknowledged is not a
  // candidate, so a held wk_done is never collected twice. The rotating
  // search is split into "first candidate at or above rr" and "first
  // candidate overall" so every bit select stays constant.
  always_comb begin
    w_cand     = wk_done & r_busyf & ~r_wk_ack;
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_found = 1'b0;
    w_lo_idx   = '0;
    for (int unsigned i = 0; i < NW; i++) begin
      if (!w_hi_found && w_cand[i] && (IW'(i) >= r_rr)) begin
        w_hi_found = 1'b1;
        w_hi_idx   = IW'(i);
      end
      if (!w_lo_found && w_cand[i]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = IW'(i);
      end
    end
    w_gnt_valid = (r_state == S_RUN) && w_lo_found;
    w_gnt_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
    w_rr_nxt    = (w_gnt_idx == IW'(NUM_WORKERS - 1)) ? '0 : w_gnt_idx + IW'(1);
  end

  // Dispatch: lowest-index idle worker while nonces remain. Busy flags drop
  // on the edge that ends the ack cycle, so redispatch comes strictly later.
  always_comb begin
    w_free_found = 1'b0;
    w_d_idx      = '0;
    for (int unsigned i = 0; i < NW; i++) begin
      if (!w_free_found && !r_busyf[i]) begin
        w_free_found = 1'b1;
        w_d_idx      = IW'(i);
      end
    end
    w_disp     = (r_state == S_RUN) && w_free_found && (r_next < r_count);
    w_busy_nxt = r_busyf & ~r_wk_ack;
    if (w_disp) begin
      w_busy_nxt[w_d_idx] = 1'b1;
    end
  end

  // Nonce tag per worker; always written before it can be read back.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && start && nonce_count != '0) begin
      r_tag[0] <= '0;
    end else if (w_disp) begin
      r_tag[w_d_idx] <= r_next;
    end
  end

  // Job FSM, dispatch/collection bookkeeping and registered outputs.
  // Accepting a non-empty job also dispatches nonce 0 to worker 0 on the
  // same edge so the first launch follows start without a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_base      <= '0;
      r_next      <= '0;
      r_written   <= '0;
      r_busyf     <= '0;
      r_rr        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wk_start  <= '0;
      r_wk_nonce  <= '0;
      r_wk_ack    <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_wk_start <= '0;
      r_wk_ack   <= '0;
      r_mem_we   <= 1'b0;
      r_done     <= 1'b0;
      r_busyf    <= w_busy_nxt;

      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          if (start) begin
            r_count   <= nonce_count;
            r_base    <= output_addr;
            r_written <= '0;
            r_busy    <= 1'b1;
            if (nonce_count == '0) begin
              r_next  <= '0;
              r_busyf <= '0;
              r_state <= S_FIN;
            end else begin
              r_next     <= NONCE_W'(1);
              r_busyf    <= NUM_WORKERS'(1);
              r_wk_start <= NUM_WORKERS'(1);
              r_wk_nonce <= '0;
              r_state    <= S_RUN;
            end
          end
        end

        S_RUN: begin
          r_busy <= 1'b1;
          if (w_disp) begin
            r_wk_start[w_d_idx] <= 1'b1;
            r_wk_nonce          <= 32'(r_next);
            r_next              <= r_next + NONCE_W'(1);
          end
          if (w_gnt_valid) begin
            r_mem_we            <= 1'b1;
            r_mem_addr          <= r_base + 16'(r_tag[w_gnt_idx]);
            r_mem_wdata         <= w_res[w_gnt_idx];
            r_wk_ack[w_gnt_idx] <= 1'b1;
            r_rr                <= w_rr_nxt;
            r_written           <= r_written + NONCE_W'(1);
          end
          if (r_written == r_count) begin
            r_state <= S_FIN;
          end
        end

        S_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_scheduler.sv
// Directed bench for nonce_scheduler with a small behavioural worker pool.
module tb_nonce_scheduler;

  localparam int NW = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [5:0]   nonce_count;
  logic [15:0]  output_addr;
  logic         busy;
  logic         done;
  logic [3:0]   wk_start;
  logic [31:0]  wk_nonce;
  logic [3:0]   wk_done;
  logic [127:0] wk_result;
  logic [3:0]   wk_ack;
  logic         mem_we;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_write_data;

  always #5 clk = ~clk;

  nonce_scheduler #(.NUM_WORKERS(NW), .NONCE_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .nonce_count(nonce_count),
    .output_addr(output_addr), .busy(busy), .done(done), .wk_start(wk_start),
    .wk_nonce(wk_nonce), .wk_done(wk_done), .wk_result(wk_result),
    .wk_ack(wk_ack), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data)
  );

  // Worker pool: latency-driven workers (lat=0 disables) plus manual overrides
  logic        wk_rst;
  int          lat [NW];
  logic [31:0] res_base;
  logic [3:0]  man_done;
  logic [31:0] man_res [NW];
  logic [3:0]  auto_done;
  logic [31:0] auto_res [NW];
  int          cnt [NW];
  logic [3:0]  act;
  logic [31:0] wnonce [NW];

  assign wk_done = auto_done | man_done;
  for (genvar g = 0; g < NW; g++) begin : g_wr
    assign wk_result[32*g +: 32] = man_done[g] ? man_res[g] : auto_res[g];
  end

  always @(posedge clk or posedge wk_rst) begin
    if (wk_rst) begin
      auto_done <= '0;
      act       <= '0;
      for (int i = 0; i < NW; i++) begin
        cnt[i]      <= 0;
        auto_res[i] <= '0;
        wnonce[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NW; i++) begin
        if (wk_ack[i]) begin
          auto_done[i] <= 1'b0;
          act[i]       <= 1'b0;
        end else if (wk_start[i] && lat[i] != 0) begin
          act[i]    <= 1'b1;
          cnt[i]    <= lat[i] - 1;
          wnonce[i] <= wk_nonce;
        end else if (act[i] && !auto_done[i]) begin
          if (cnt[i] <= 1) begin
            auto_done[i] <= 1'b1;
            auto_res[i]  <= res_base ^ wnonce[i];
          end else begin
            cnt[i] <= cnt[i] - 1;
          end
        end
      end
    end
  end

  // Event log sampled on the falling edge
  int          n_start = 0;
  int          n_ack   = 0;
  logic [31:0] dn [$];
  logic [15:0] wa [$];
  logic [31:0] wd [$];

  always @(negedge clk) begin
    if (|wk_start) begin
      n_start++;
      dn.push_back(wk_nonce);
    end
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_write_data);
    end
    if (|wk_ack) n_ack++;
  end

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int maxc, input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < maxc) begin
      tick();
      n++;
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_wkstart"}, 64'(wk_start), 64'd0);
    chk({tag, "_wkack"}, 64'(wk_ack), 64'd0);
    chk({tag, "_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_data"}, 64'(mem_write_data), 64'd0);
    chk({tag, "_nonce"}, 64'(wk_nonce), 64'd0);
  endtask

  initial begin
    int          s0, w0, d0, n, hits;
    logic [3:0]  ev;
    logic [15:0] exp_a [4];

    reset = 1'b1; wk_rst = 1'b1; start = 1'b0; nonce_count = '0; output_addr = '0;
    man_done = '0; res_base = '0;
    for (int i = 0; i < NW; i++) begin lat[i] = 0; man_res[i] = '0; end
    tick(); tick();
    chk_zero("rst");
    reset = 1'b0; wk_rst = 1'b0;

    // Empty job: FIN then a done pulse, no launches, no writes
    s0 = n_start; w0 = wa.size();
    nonce_count = 6'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_done_early", 64'(done), 64'd0);
    tick();
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_idle", 64'(busy), 64'd0);
    tick();
    chk("t1_done_once", 64'(done), 64'd0);
    chk("t1_nstart", 64'(n_start - s0), 64'd0);
    chk("t1_nwe", 64'(wa.size() - w0), 64'd0);

    // Single nonce, 10-cycle worker
    for (int i = 0; i < NW; i++) lat[i] = 10;
    res_base = 32'hDEADBEEF;
    s0 = n_start; w0 = wa.size();
    nonce_count = 6'd1; output_addr = 16'h0100; start = 1'b1;
    tick(); start = 1'b0;
    chk("t2_wkstart", 64'(wk_start), 64'h1);
    chk("t2_nonce", 64'(wk_nonce), 64'h0);
    n = 0;
    while (mem_we !== 1'b1 && n < 60) begin tick(); n++; end
    chk("t2_latency", 64'(n), 64'd11);
    chk("t2_addr", 64'(mem_addr), 64'h0100);
    chk("t2_data", 64'(mem_write_data), 64'hDEADBEEF);
    chk("t2_ack", 64'(wk_ack), 64'h1);
    tick();
    chk("t2_we_off", 64'(mem_we), 64'd0);
    chk("t2_ack_off", 64'(wk_ack), 64'd0);
    tick();
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_idle", 64'(busy), 64'd0);
    chk("t2_nwrites", 64'(wa.size() - w0), 64'd1);
    chk("t2_nstart", 64'(n_start - s0), 64'd1);

    // Sixteen nonces over four workers, fixed 20-cycle latency
    for (int i = 0; i < NW; i++) lat[i] = 20;
    res_base = 32'h1234_0000;
    w0 = wa.size(); d0 = dn.size();
    nonce_count = 6'd16; output_addr = 16'h0200; start = 1'b1;
    tick(); start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) tick();
      ev = 4'(1 << k);
      chk("t3_wkstart", 64'(wk_start), 64'(ev));
      chk("t3_nonce", 64'(wk_nonce), 64'(k));
    end
    wait_done(600, "t3_done");
    chk("t3_nwrites", 64'(wa.size() - w0), 64'd16);
    chk("t3_ndisp", 64'(dn.size() - d0), 64'd16);
    for (int k = 0; k < 16; k++) begin
      hits = 0;
      for (int j = w0; j < wa.size(); j++) begin
        if (wa[j] == 16'(16'h0200 + k)) begin
          hits++;
          chk("t3_data", 64'(wd[j]), 64'(32'h1234_0000 ^ k));
        end
      end
      chk("t3_addr_once", 64'(hits), 64'd1);
      hits = 0;
      for (int j = d0; j < dn.size(); j++) if (dn[j] == 32'(k)) hits++;
      chk("t3_disp_once", 64'(hits), 64'd1);
    end
    tick();

    // Fresh reset (rr=0), then all four results presented together
    reset = 1'b1; wk_rst = 1'b1;
    tick();
    reset = 1'b0; wk_rst = 1'b0;
    for (int i = 0; i < NW; i++) begin lat[i] = 0; man_res[i] = 32'hC0DE_0000 + 32'(i); end
    nonce_count = 6'd4; output_addr = 16'h0300; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("t4_last_launch", 64'(wk_start), 64'h8);
    tick();
    man_done = 4'hF;
    for (int k = 0; k < 4; k++) begin
      tick();
      ev = 4'(1 << k);
      chk("t4_ack", 64'(wk_ack), 64'(ev));
      chk("t4_we", 64'(mem_we), 64'd1);
      chk("t4_addr", 64'(mem_addr), 64'(16'h0300 + k));
      chk("t4_data", 64'(mem_write_data), 64'(32'hC0DE_0000 + k));
    end
    man_done = '0;
    wait_done(20, "t4_done");
    tick();

    // rr back at 0: simultaneous results from workers 0 and 1 grant 0 first
    for (int i = 0; i < NW; i++) man_res[i] = 32'hAAAA_0000 + 32'(i);
    nonce_count = 6'd2; output_addr = 16'h0400; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk("t5_launch1", 64'(wk_start), 64'h2);
    tick();
    man_done = 4'b0011;
    tick();
    chk("t5_ack0", 64'(wk_ack), 64'h1);
    chk("t5_addr0", 64'(mem_addr), 64'h0400);
    chk("t5_data0", 64'(mem_write_data), 64'hAAAA_0000);
    tick();
    chk("t5_ack1", 64'(wk_ack), 64'h2);
    chk("t5_addr1", 64'(mem_addr), 64'h0401);
    man_done = '0;
    wait_done(20, "t5_done");
    tick();

    // Address wrap at the top of the 16-bit space
    for (int i = 0; i < NW; i++) lat[i] = 5;
    res_base = 32'h5555_0000;
    w0 = wa.size();
    nonce_count = 6'd4; output_addr = 16'hFFFE; start = 1'b1;
    tick(); start = 1'b0;
    wait_done(100, "t6_done");
    chk("t6_nwrites", 64'(wa.size() - w0), 64'd4);
    exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
    if (wa.size() - w0 == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("t6_addr", 64'(wa[w0+k]), 64'(exp_a[k]));
        chk("t6_data", 64'(wd[w0+k]), 64'(32'h5555_0000 ^ k));
      end
    end
    tick();

    // Asynchronous reset while two workers are busy
    for (int i = 0; i < NW; i++) lat[i] = 30;
    res_base = 32'h7777_0000;
    nonce_count = 6'd2; output_addr = 16'h0500; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk("t7_launch1", 64'(wk_start), 64'h2);
    tick();
    chk("t7_busy", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1 chk_zero("t7_async");
    @(posedge clk); #1 reset = 1'b0;
    s0 = n_ack; w0 = wa.size();
    repeat (45) tick();
    chk("t7_no_ack", 64'(n_ack - s0), 64'd0);
    chk("t7_no_write", 64'(wa.size() - w0), 64'd0);
    chk("t7_idle", 64'(busy), 64'd0);
    reset = 1'b1; wk_rst = 1'b1;
    tick();
    reset = 1'b0; wk_rst = 1'b0;
    for (int i = 0; i < NW; i++) lat[i] = 3;
    res_base = 32'h9999_0000;
    w0 = wa.size();
    nonce_count = 6'd1; output_addr = 16'h0600; start = 1'b1;
    tick(); start = 1'b0;
    chk("t7_restart_wk", 64'(wk_start), 64'h1);
    chk("t7_restart_nonce", 64'(wk_nonce), 64'h0);
    wait_done(40, "t7_done");
    chk("t7_nwrites", 64'(wa.size() - w0), 64'd1);
    if (wa.size() - w0 == 1) begin
      chk("t7_addr", 64'(wa[w0]), 64'h0600);
      chk("t7_data", 64'(wd[w0]), 64'h9999_0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
